rv32e_alu_issue: RTL and testbench
==================================

# rv32e_alu_issue

Execute-stage issue/writeback wrapper that sits in front of the combinational RV32E ALU. It accepts instructions with their operand values over a valid/ready handshake and decodes them into the ALU's 4-bit op code and operand pair. It captures the ALU result into a registered writeback/branch output. It is a two-stage, fully stallable pipeline with one instruction per cycle throughput.

## Interface
- No parameters; widths fixed (XLEN 32, 16 architectural registers).
- `clk` in 1 — single clock, all state on rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `in_valid` in 1 — instruction offered.
- `in_ready` out 1 — stage 1 can accept.
- `in_instr` in 32 — raw instruction word.
- `in_pc` in 32 — instruction address.
- `in_rs1_val`, `in_rs2_val` in 32 each — register operand values.
- `alu_op` out 4 — ALU op code, registered: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, SEQ=A, SNE=B, SGE=C, SGEU=D.
- `alu_a`, `alu_b` out 32 each — ALU operands, registered.
- `alu_result` in 32 — combinational ALU result for `alu_op/a/b`.
- `out_valid` out 1 — writeback record present.
- `out_ready` in 1 — consumer accepts record.
- `out_rd` out 4 — destination register.
- `out_we` out 1 — register write enable.
- `out_wdata` out 32 — write data.
- `out_branch` out 1 — record is a conditional branch.
- `out_taken` out 1 — branch taken.
- `out_target` out 32 — branch target address.
- `out_illegal` out 1 — instruction not supported by this unit.
- `retire_count` out 32 — count of output handshakes; wraps to 0 after 0xFFFFFFFF.

## Operation
- Decode by opcode `in_instr[6:0]`:
  - OP (0110011): funct3 selects ADD/SUB (funct7[5]), SLL, SLT, SLTU, XOR, SRL/SRA (funct7[5]), OR, AND. a=rs1, b=rs2. Any other funct7 is illegal.
  - OP-IMM (0010011): a=rs1, b=sign-extended I-imm. SUB is never selected. For SLLI/SRLI/SRAI, b=imm[4:0] zero-extended; funct7 must be 0000000, or 0100000 for SRAI.
  - LUI: op ADD, a=0, b={instr[31:12],12'b0}.
  - AUIPC: op ADD, a=pc, b=U-imm.
  - BRANCH (1100011): BEQ→SEQ, BNE→SNE, BLT→SLT, BGE→SGE, BLTU→SLTU, BGEU→SGEU; a=rs1, b=rs2. funct3 010/011 is illegal.
- Illegal cases: any other opcode, or bit 4 set in any used rd/rs1/rs2 field (RV32E). An illegal instruction passes through with `out_illegal`=1, `out_we`=0, `out_branch`=0, and op ADD with a=b=0.
- Stage 1 registers op/a/b, rd, we, branch flag, illegal flag and target. Target is pc + sign-extended B-imm from a dedicated adder, not the ALU.
- Stage 2 captures: wdata=`alu_result`; taken=`alu_result[0]` when branch, else 0.
- `out_we`=1 only for legal non-branch instructions with rd≠0. Branches write nothing; rd=0 gives we=0 with wdata still captured.

## Timing
- Reset: all valids 0. `alu_op`=0, `alu_a`=`alu_b`=0. Every out_* field 0. `retire_count`=0. Reset mid-stream discards both stages immediately.
- advance2 = !out_valid | out_ready.
- in_ready = !s1_valid | advance2 (combinational; depends on `out_ready`).
- Input handshake at edge k → stage 1 valid after k. If advance2 holds at edge k+1, the record appears on out_* after k+1. Latency: 2 edges. Throughput: 1/cycle with out_ready held high.
- While out_valid & !out_ready, all out_* fields and stage 1 (including the `alu_*` drive) hold stable.
- A simultaneous output handshake and new capture at one edge is legal; no bubble is inserted.
- `alu_*` holds its last value when stage 1 is empty.
- retire_count increments on each out_valid & out_ready edge.

## Test plan
- ADD x3,x1,x2 with rs1=5, rs2=7, ALU model attached, out_ready=1 → two edges later: out_rd=3, out_we=1, out_wdata=12; `alu_op`=0 seen for one cycle.
- SRAI x5,x6,4 with rs1=0x80000000 → alu_op=7, alu_b=4, out_wdata=0xF8000000.
- BLT at pc 0x100, imm −8, rs1=0xFFFFFFFF, rs2=1 → out_branch=1, out_taken=1, out_target=0xF8, out_we=0.
- ADD x17,x1,x2 (rd bit 4 set) → out_illegal=1, out_we=0. LUI x0,0x12345 → out_we=0, out_wdata=0x12345000.
- Back-to-back stream of 4 instructions, out_ready low for 3 cycles mid-stream → in_ready drops once both stages are full, no record lost or duplicated, records hold stable during the stall, retire_count=4 at end.
- rst_n asserted while both stages are full → out_valid=0 and retire_count=0 immediately, asynchronously; a new instruction is accepted on the first edge after release.

Source files
------------

// File: rtl/rv32e_alu_issue.sv
// Issue/writeback wrapper around a combinational RV32E ALU: decodes instructions into
// op/operand registers (stage 1) and captures the ALU result into a writeback record (stage 2).
module rv32e_alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1_val,
  input  logic [31:0] in_rs2_val,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_rd,
  output logic        out_we,
  output logic [31:0] out_wdata,
  output logic        out_branch,
  output logic        out_taken,
  output logic [31:0] out_target,
  output logic        out_illegal,
  output logic [31:0] retire_count
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
    OP_XOR  = 4'h4, OP_SLL  = 4'h5, OP_SRL = 4'h6, OP_SRA = 4'h7,
    OP_SLT  = 4'h8, OP_SLTU = 4'h9, OP_SEQ = 4'hA, OP_SNE = 4'hB,
    OP_SGE  = 4'hC, OP_SGEU = 4'hD
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_u, imm_b;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign funct7 = in_instr[31:25];
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign imm_b  = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};

  alu_op_e     d_op;
  logic [31:0] d_a, d_b;
  logic        d_legal, d_writes_rd, d_uses_rs1, d_uses_rs2, d_branch;
  logic        d_illegal, d_we;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned,
  // which keeps this block purely combinational (no inferred latches).
  always_comb begin
    d_op        = OP_ADD;
    d_a         = '0;
    d_b         = '0;
    d_legal     = 1'b1;
    d_writes_rd = 1'b0;
    d_uses_rs1  = 1'b0;
    d_uses_rs2  = 1'b0;
    d_branch    = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        d_writes_rd = 1'b1;
        d_uses_rs1  = 1'b1;
        d_uses_rs2  = 1'b1;
        d_a         = in_rs1_val;
        d_b         = in_rs2_val;
        if (funct7 == 7'b0100000) begin
          d_legal = (funct3 == 3'b000) || (funct3 == 3'b101);
          d_op    = (funct3 == 3'b101) ? OP_SRA : OP_SUB;
        end else if (funct7 != 7'b0000000) begin
          d_legal = 1'b0;
        end else begin
          unique case (funct3)
            3'b000:  d_op = OP_ADD;
            3'b001:  d_op = OP_SLL;
            3'b010:  d_op = OP_SLT;
            3'b011:  d_op = OP_SLTU;
            3'b100:  d_op = OP_XOR;
            3'b101:  d_op = OP_SRL;
            3'b110:  d_op = OP_OR;
            default: d_op = OP_AND;
          endcase
        end
      end
      OPC_OP_IMM: begin
        d_writes_rd = 1'b1;
        d_uses_rs1  = 1'b1;
        d_a         = in_rs1_val;
        d_b         = imm_i;
        unique case (funct3)
          3'b000:  d_op = OP_ADD;
          3'b010:  d_op = OP_SLT;
          3'b011:  d_op = OP_SLTU;
          3'b100:  d_op = OP_XOR;
          3'b110:  d_op = OP_OR;
          3'b111:  d_op = OP_AND;
          3'b001: begin
            d_op    = OP_SLL;
            d_b     = {27'b0, in_instr[24:20]};
            d_legal = (funct7 == 7'b0000000);
          end
          default: begin
            d_op    = (funct7 == 7'b0100000) ? OP_SRA : OP_SRL;
            d_b     = {27'b0, in_instr[24:20]};
            d_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          end
        endcase
      end
      OPC_LUI: begin
        d_writes_rd = 1'b1;
        d_b         = imm_u;
      end
      OPC_AUIPC: begin
        d_writes_rd = 1'b1;
        d_a         = in_pc;
        d_b         = imm_u;
      end
      OPC_BRANCH: begin
        d_branch   = 1'b1;
        d_uses_rs1 = 1'b1;
        d_uses_rs2 = 1'b1;
        d_a        = in_rs1_val;
        d_b        = in_rs2_val;
        unique case (funct3)
          3'b000:  d_op = OP_SEQ;
          3'b001:  d_op = OP_SNE;
          3'b100:  d_op = OP_SLT;
          3'b101:  d_op = OP_SGE;
          3'b110:  d_op = OP_SLTU;
          3'b111:  d_op = OP_SGEU;
          default: d_legal = 1'b0;
        endcase
      end
      default: d_legal = 1'b0;
    endcase

    // RV32E has only x0..x15, so bit 4 of any register field in use is illegal.
    d_illegal = !d_legal || (d_writes_rd && rd[4]) ||
                (d_uses_rs1 && rs1[4]) || (d_uses_rs2 && rs2[4]);
    if (d_illegal) begin
      d_op     = OP_ADD;
      d_a      = '0;
      d_b      = '0;
      d_branch = 1'b0;
    end
    d_we = !d_illegal && !d_branch && (rd != 5'd0);
  end

  logic        s1_valid, s1_we, s1_branch, s1_illegal;
  logic [3:0]  s1_rd;
  logic [31:0] s1_target;
  logic        advance2, accept;

  assign advance2 = !out_valid || out_ready;
  assign in_ready = !s1_valid || advance2;
  assign accept   = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; all state here is plain flops, so every one gets an async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      alu_op     <= OP_ADD;
      alu_a      <= '0;
      alu_b      <= '0;
      s1_rd      <= '0;
      s1_we      <= 1'b0;
      s1_branch  <= 1'b0;
      s1_illegal <= 1'b0;
      s1_target  <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (accept) begin
        alu_op     <= d_op;
        alu_a      <= d_a;
        alu_b      <= d_b;
        s1_rd      <= rd[3:0];
        s1_we      <= d_we;
        s1_branch  <= d_branch;
        s1_illegal <= d_illegal;
        s1_target  <= in_pc + imm_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_rd       <= '0;
      out_we       <= 1'b0;
      out_wdata    <= '0;
      out_branch   <= 1'b0;
      out_taken    <= 1'b0;
      out_target   <= '0;
      out_illegal  <= 1'b0;
      retire_count <= '0;
    end else begin
      if (advance2) out_valid <= s1_valid;
      if (advance2 && s1_valid) begin
        out_rd      <= s1_rd;
        out_we      <= s1_we;
        out_wdata   <= alu_result;
        out_branch  <= s1_branch;
        out_taken   <= s1_branch && alu_result[0];
        out_target  <= s1_target;
        out_illegal <= s1_illegal;
      end
      if (out_valid && out_ready) retire_count <= retire_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_rv32e_alu_issue.sv
// Directed bench for rv32e_alu_issue: table of single instructions, a stalled stream,
// and a reset while both stages are full. A behavioural ALU is attached to alu_*.
module tb_rv32e_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc, in_rs1_val, in_rs2_val;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        out_valid, out_ready;
  logic [3:0]  out_rd;
  logic        out_we, out_branch, out_taken, out_illegal;
  logic [31:0] out_wdata, out_target, retire_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rv32e_alu_issue dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_we(out_we),
    .out_wdata(out_wdata), .out_branch(out_branch), .out_taken(out_taken),
    .out_target(out_target), .out_illegal(out_illegal), .retire_count(retire_count)
  );

  // Reference ALU driven by the registered op/operands.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      4'h0: alu_result = alu_a + alu_b;
      4'h1: alu_result = alu_a - alu_b;
      4'h2: alu_result = alu_a & alu_b;
      4'h3: alu_result = alu_a | alu_b;
      4'h4: alu_result = alu_a ^ alu_b;
      4'h5: alu_result = alu_a << alu_b[4:0];
      4'h6: alu_result = alu_a >> alu_b[4:0];
      4'h7: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      4'h8: alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
      4'h9: alu_result = {31'b0, alu_a < alu_b};
      4'hA: alu_result = {31'b0, alu_a == alu_b};
      4'hB: alu_result = {31'b0, alu_a != alu_b};
      4'hC: alu_result = {31'b0, $signed(alu_a) >= $signed(alu_b)};
      4'hD: alu_result = {31'b0, alu_a >= alu_b};
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] instr, pc, rs1, rs2;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [3:0]  rd;
    logic        we;
    logic [31:0] wdata;
    logic        br, tk;
    logic [31:0] tgt;
    logic        ill;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [31:0] addi_enc(input int rdn, input int imm);
    logic [31:0] w;
    w = 32'h13;
    w[11:7]  = rdn[4:0];
    w[31:20] = imm[11:0];
    return w;
  endfunction

  initial begin
    logic [3:0]  held_rd;
    logic [31:0] held_wdata;
    logic        prev_acc, stalled, saw_block;
    int          tx, rx;

    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    in_rs1_val = '0; in_rs2_val = '0; out_ready = 1'b1;

    //          instr          pc            rs1           rs2           op    a             b             rd  we wdata         br tk tgt           ill
    vecs[0]  = '{32'h002081B3, 32'h0,        32'd5,        32'd7,        4'h0, 32'd5,        32'd7,        3,  1, 32'd12,       0, 0, 32'h0,        0}; // ADD x3
    vecs[1]  = '{32'h40435293, 32'h0,        32'h80000000, 32'h0,        4'h7, 32'h80000000, 32'd4,        5,  1, 32'hF8000000, 0, 0, 32'h0,        0}; // SRAI x5
    vecs[2]  = '{32'hFE20CCE3, 32'h100,      32'hFFFFFFFF, 32'd1,        4'h8, 32'hFFFFFFFF, 32'd1,        0,  0, 32'd1,        1, 1, 32'hF8,       0}; // BLT -8
    vecs[3]  = '{32'h002088B3, 32'h0,        32'd5,        32'd7,        4'h0, 32'h0,        32'h0,        0,  0, 32'h0,        0, 0, 32'h0,        1}; // ADD x17
    vecs[4]  = '{32'h12345037, 32'h0,        32'h0,        32'h0,        4'h0, 32'h0,        32'h12345000, 0,  0, 32'h12345000, 0, 0, 32'h0,        0}; // LUI x0
    vecs[5]  = '{32'h00001217, 32'h200,      32'h0,        32'h0,        4'h0, 32'h200,      32'h1000,     4,  1, 32'h1200,     0, 0, 32'h0,        0}; // AUIPC x4
    vecs[6]  = '{32'hFFF08393, 32'h0,        32'd10,       32'h0,        4'h0, 32'd10,       32'hFFFFFFFF, 7,  1, 32'd9,        0, 0, 32'h0,        0}; // ADDI -1
    vecs[7]  = '{32'h40208433, 32'h0,        32'd5,        32'd7,        4'h1, 32'd5,        32'd7,        8,  1, 32'hFFFFFFFE, 0, 0, 32'h0,        0}; // SUB x8
    vecs[8]  = '{32'h0020B4B3, 32'h0,        32'hFFFFFFFF, 32'd1,        4'h9, 32'hFFFFFFFF, 32'd1,        9,  1, 32'd0,        0, 0, 32'h0,        0}; // SLTU
    vecs[9]  = '{32'h00208463, 32'h40,       32'd3,        32'd4,        4'hA, 32'd3,        32'd4,        0,  0, 32'd0,        1, 0, 32'h48,       0}; // BEQ nt
    vecs[10] = '{32'h00002003, 32'h0,        32'd1,        32'd2,        4'h0, 32'h0,        32'h0,        0,  0, 32'h0,        0, 0, 32'h0,        1}; // LW
    vecs[11] = '{32'h022081B3, 32'h0,        32'd5,        32'd7,        4'h0, 32'h0,        32'h0,        0,  0, 32'h0,        0, 0, 32'h0,        1}; // MUL
    vecs[12] = '{32'h0020A063, 32'h0,        32'd5,        32'd7,        4'h0, 32'h0,        32'h0,        0,  0, 32'h0,        0, 0, 32'h0,        1}; // branch f3=010

    #12;
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset alu_op", {28'b0, alu_op}, 32'd0);
    check("reset alu_a", alu_a, 32'd0);
    check("reset alu_b", alu_b, 32'd0);
    check("reset out_wdata", out_wdata, 32'd0);
    check("reset retire_count", retire_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_instr = vecs[i].instr; in_pc = vecs[i].pc;
      in_rs1_val = vecs[i].rs1; in_rs2_val = vecs[i].rs2;
      #1 check($sformatf("v%0d in_ready", i), {31'b0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("v%0d alu_op", i), {28'b0, alu_op}, {28'b0, vecs[i].op});
      check($sformatf("v%0d alu_a", i), alu_a, vecs[i].a);
      check($sformatf("v%0d alu_b", i), alu_b, vecs[i].b);
      @(negedge clk);
      check($sformatf("v%0d out_valid", i), {31'b0, out_valid}, 32'd1);
      check($sformatf("v%0d alu_op held", i), {28'b0, alu_op}, {28'b0, vecs[i].op});
      if (!vecs[i].br && !vecs[i].ill)
        check($sformatf("v%0d out_rd", i), {28'b0, out_rd}, {28'b0, vecs[i].rd});
      check($sformatf("v%0d out_we", i), {31'b0, out_we}, {31'b0, vecs[i].we});
      check($sformatf("v%0d out_wdata", i), out_wdata, vecs[i].wdata);
      check($sformatf("v%0d out_branch", i), {31'b0, out_branch}, {31'b0, vecs[i].br});
      check($sformatf("v%0d out_taken", i), {31'b0, out_taken}, {31'b0, vecs[i].tk});
      check($sformatf("v%0d out_illegal", i), {31'b0, out_illegal}, {31'b0, vecs[i].ill});
      if (vecs[i].br)
        check($sformatf("v%0d out_target", i), out_target, vecs[i].tgt);
      @(negedge clk);
      check($sformatf("v%0d drained", i), {31'b0, out_valid}, 32'd0);
    end
    check("retire after table", retire_count, 32'd13);

    // Reset between phases so retire_count starts from zero for the stream.
    rst_n = 1'b0;
    #1 rst_n = 1'b1;

    // Four back-to-back ADDIs with out_ready low for three cycles mid-stream.
    tx = 0; rx = 0; prev_acc = 1'b0; stalled = 1'b0; saw_block = 1'b0;
    held_rd = '0; held_wdata = '0;
    in_rs1_val = '0; in_rs2_val = '0; in_pc = '0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (prev_acc) tx++;
      if (stalled) begin
        check($sformatf("stall c%0d rd stable", cyc), {28'b0, out_rd}, {28'b0, held_rd});
        check($sformatf("stall c%0d wdata stable", cyc), out_wdata, held_wdata);
        check($sformatf("stall c%0d valid stable", cyc), {31'b0, out_valid}, 32'd1);
      end
      out_ready = !(cyc >= 3 && cyc < 6);
      if (tx < 4) begin
        in_valid = 1'b1;
        in_instr = addi_enc(tx + 1, 10 + tx + 1);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      prev_acc = in_valid && in_ready;
      if (!in_ready) saw_block = 1'b1;
      if (out_valid && out_ready) begin
        check($sformatf("stream rec%0d rd", rx), {28'b0, out_rd}, 4'(rx + 1));
        check($sformatf("stream rec%0d wdata", rx), out_wdata, 32'(11 + rx));
        check($sformatf("stream rec%0d we", rx), {31'b0, out_we}, 32'd1);
        rx++;
      end
      stalled = out_valid && !out_ready;
      held_rd = out_rd;
      held_wdata = out_wdata;
    end
    check("stream sent", 32'(tx), 32'd4);
    check("stream received", 32'(rx), 32'd4);
    check("stream in_ready dropped", {31'b0, saw_block}, 32'd1);
    check("stream retire_count", retire_count, 32'd4);

    // Fill both stages with out_ready low, then reset asynchronously mid-cycle.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = addi_enc(1, 1);
    @(negedge clk);
    in_instr = addi_enc(2, 2);
    @(negedge clk);
    in_valid = 1'b0;
    check("full out_valid", {31'b0, out_valid}, 32'd1);
    check("full in_ready low", {31'b0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async rst out_valid", {31'b0, out_valid}, 32'd0);
    check("async rst retire_count", retire_count, 32'd0);
    check("async rst alu_b", alu_b, 32'd0);
    check("async rst out_rd", {28'b0, out_rd}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = addi_enc(6, 77); in_rs1_val = 32'd3;
    #1 check("post-reset in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("post-reset alu_b", alu_b, 32'd77);
    @(negedge clk);
    check("post-reset out_valid", {31'b0, out_valid}, 32'd1);
    check("post-reset out_wdata", out_wdata, 32'd80);
    check("post-reset out_rd", {28'b0, out_rd}, 32'd6);
    @(negedge clk);
    check("post-reset retire_count", retire_count, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
